// File: rtl/ysyx_22040632_div_unit.sv
// Iterative radix-2 restoring divider for the RV64M div/rem group, one quotient bit per cycle.
// Divide-by-zero and signed overflow resolve at accept and skip the iteration.
module ysyx_22040632_div_unit #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rrst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  input  logic            div_word,
  input  logic            div_signed,
  input  logic            div_rem,
  input  logic            flush,
  output logic            busy,
  output logic            out_valid,
  output logic [XLEN-1:0] result,
  output logic [1:0]      dbg_state
);

  // Handshake: a request transfers on the clk edge where in_valid && in_ready && !flush;
  // the requester holds operands and flags stable while in_valid is high.
  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

  state_t            state_q;
  logic [CW-1:0]     cnt_q;
  logic [XLEN-1:0]   rem_q, quo_q, dvs_q, result_q;
  logic              word_q, rem_sel_q, neg_quo_q, neg_rem_q;

  logic [XLEN-1:0]   a_ext, b_ext, a_mag, b_mag, spec_raw, spec_val;
  logic              a_neg, b_neg, b_zero, ovf;
  logic [XLEN:0]     rem_sh, diff;
  logic              ge;
  logic [XLEN-1:0]   rem_nxt, quo_nxt, q_fix, r_fix, sel_val, fin_val;

  always_comb begin
    a_ext  = div_word ? {{(XLEN-32){div_signed & dividend[31]}}, dividend[31:0]} : dividend;
    b_ext  = div_word ? {{(XLEN-32){div_signed & divisor[31]}}, divisor[31:0]} : divisor;
    a_neg  = div_signed & a_ext[XLEN-1];
    b_neg  = div_signed & b_ext[XLEN-1];
    a_mag  = a_neg ? -a_ext : a_ext;
    b_mag  = b_neg ? -b_ext : b_ext;
    b_zero = (b_ext == '0);
    ovf    = div_signed && (b_ext == '1) &&
             (div_word ? (dividend[31:0] == 32'h8000_0000)
                       : (dividend == {1'b1, {(XLEN-1){1'b0}}}));
    if (b_zero) spec_raw = div_rem ? dividend : '1;
    else        spec_raw = div_rem ? '0 : dividend;
    spec_val = div_word ? {{(XLEN-32){spec_raw[31]}}, spec_raw[31:0]} : spec_raw;
  end

  // Shifted partial remainder needs one extra bit: it can exceed 2^XLEN-1 for unsigned divisors.
  always_comb begin
    rem_sh  = {rem_q, quo_q[XLEN-1]};
    diff    = rem_sh - {1'b0, dvs_q};
    ge      = (rem_sh >= {1'b0, dvs_q});
    rem_nxt = ge ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
    quo_nxt = {quo_q[XLEN-2:0], ge};
    q_fix   = neg_quo_q ? -quo_nxt : quo_nxt;
    r_fix   = neg_rem_q ? -rem_nxt : rem_nxt;
    sel_val = rem_sel_q ? r_fix : q_fix;
    fin_val = word_q ? {{(XLEN-32){sel_val[31]}}, sel_val[31:0]} : sel_val;
  end

  always_ff @(posedge clk or negedge rrst_n) begin
    if (!rrst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      result_q  <= '0;
      word_q    <= 1'b0;
      rem_sel_q <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!flush && in_valid) begin
            word_q    <= div_word;
            rem_sel_q <= div_rem;
            neg_quo_q <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
            rem_q     <= '0;
            // W-form dividend sits in the top half so the MSB-first shift is the same for both widths.
            quo_q     <= div_word ? {a_mag[31:0], {(XLEN-32){1'b0}}} : a_mag;
            dvs_q     <= b_mag;
            if (b_zero || ovf) begin
              state_q  <= DONE;
              result_q <= spec_val;
            end else begin
              state_q <= CALC;
              cnt_q   <= div_word ? CW'(31) : CW'(XLEN-1);
            end
          end
        end
        CALC: begin
          if (flush) begin
            state_q <= IDLE;
          end else begin
            rem_q <= rem_nxt;
            quo_q <= quo_nxt;
            cnt_q <= cnt_q - CW'(1);
            if (cnt_q == '0) begin
              state_q  <= DONE;
              result_q <= fin_val;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == DONE) && !flush;
  assign result    = result_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_ysyx_22040632_div_unit.sv
// Directed bench for the iterative divider: results, latency, special cases, flush and reset.
module tb_ysyx_22040632_div_unit;

  logic        clk = 1'b0;
  logic        rrst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] dividend = '0;
  logic [63:0] divisor = '0;
  logic        div_word = 1'b0;
  logic        div_signed = 1'b0;
  logic        div_rem = 1'b0;
  logic        flush = 1'b0;
  logic        busy;
  logic        out_valid;
  logic [63:0] result;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad = 0;
  logic [63:0] exp_q[$];

  ysyx_22040632_div_unit #(.XLEN(64)) dut (
    .clk(clk), .rrst_n(rrst_n), .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor), .div_word(div_word),
    .div_signed(div_signed), .div_rem(div_rem), .flush(flush),
    .busy(busy), .out_valid(out_valid), .result(result), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%016h exp=0x%016h", tag, got, exp);
    end
  endtask

  // Issue one request, wait (bounded) for out_valid, compare against the queued expectation.
  task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                        input logic w, input logic s, input logic r,
                        input logic [63:0] exp_res, input int exp_lat);
    int lat;
    bit seen;
    logic [63:0] exp_v;
    @(posedge clk); #1;
    dividend = a; divisor = b; div_word = w; div_signed = s; div_rem = r;
    in_valid = 1'b1;
    exp_q.push_back(exp_res);
    @(negedge clk);
    chk({tag, ".ready"}, 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    seen = 1'b0;
    while (!seen && lat < 100) begin
      @(negedge clk);
      lat++;
      if (out_valid) seen = 1'b1;
    end
    chk({tag, ".valid"}, 64'(seen), 64'd1);
    chk({tag, ".lat"}, 64'(lat), 64'(exp_lat));
    exp_v = exp_q.pop_front();
    chk({tag, ".res"}, result, exp_v);
    @(negedge clk);
    chk({tag, ".pulse"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    int hits;
    #12;
    chk("rst.ready", 64'(in_ready), 64'd1);
    chk("rst.busy", 64'(busy), 64'd0);
    chk("rst.valid", 64'(out_valid), 64'd0);
    chk("rst.res", result, 64'd0);
    @(negedge clk); rrst_n = 1'b1;

    run_op("divw_100_7", 64'd100, 64'd7, 1, 1, 0, 64'h0000_0000_0000_000E, 33);
    run_op("remw_100_7", 64'd100, 64'd7, 1, 1, 1, 64'h0000_0000_0000_0002, 33);
    run_op("divw_hi_ign", 64'hDEAD_BEEF_0000_0064, 64'd7, 1, 1, 0, 64'h0000_0000_0000_000E, 33);
    run_op("remw_m7_2", 64'h0000_0000_FFFF_FFF9, 64'd2, 1, 1, 1, 64'hFFFF_FFFF_FFFF_FFFF, 33);
    run_op("div_m100_7", 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 0, 1, 0, 64'hFFFF_FFFF_FFFF_FFF2, 65);
    run_op("div_100_m7", 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 0, 1, 0, 64'hFFFF_FFFF_FFFF_FFF2, 65);
    run_op("rem_100_m7", 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 0, 1, 1, 64'h0000_0000_0000_0002, 65);
    run_op("divu_max_3", 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 0, 0, 0, 64'h5555_5555_5555_5555, 65);
    run_op("divuw_by0", 64'h0000_0000_1234_5678, 64'd0, 1, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    run_op("remuw_by0", 64'h0000_0000_1234_5678, 64'd0, 1, 0, 1, 64'h0000_0000_1234_5678, 1);
    run_op("divw_ovf", 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 1, 1, 0, 64'hFFFF_FFFF_8000_0000, 1);
    run_op("remw_ovf", 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 1, 1, 1, 64'h0, 1);
    run_op("div_ovf", 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1, 0, 64'h8000_0000_0000_0000, 1);
    run_op("divuw_ff_1", 64'h0000_0000_FFFF_FFFF, 64'd1, 1, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 33);
    run_op("remuw_ff_16", 64'h0000_0000_FFFF_FFFF, 64'd16, 1, 0, 1, 64'h0000_0000_0000_000F, 33);

    // flush together with in_valid in IDLE: request must not be taken
    @(posedge clk); #1;
    dividend = 64'd50; divisor = 64'd5; div_word = 1; div_signed = 0; div_rem = 0;
    in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("idle_flush.busy", 64'(busy), 64'd0);
    chk("idle_flush.ready", 64'(in_ready), 64'd1);

    // flush mid-CALC
    @(posedge clk); #1;
    dividend = 64'd100; divisor = 64'd7; div_word = 1; div_signed = 1; div_rem = 0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    chk("flush.valid_now", 64'(out_valid), 64'd0);
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    chk("flush.ready", 64'(in_ready), 64'd1);
    chk("flush.busy", 64'(busy), 64'd0);
    hits = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) hits++;
    end
    chk("flush.no_valid", 64'(hits), 64'd0);

    // asynchronous reset mid-CALC
    @(posedge clk); #1;
    dividend = 64'd12345; divisor = 64'd11; div_word = 0; div_signed = 0; div_rem = 0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (20) @(posedge clk);
    #2 rrst_n = 1'b0;
    #1;
    chk("rstmid.valid", 64'(out_valid), 64'd0);
    chk("rstmid.res", result, 64'd0);
    chk("rstmid.busy", 64'(busy), 64'd0);
    @(negedge clk); rrst_n = 1'b1;
    run_op("divw_9_3", 64'd9, 64'd3, 1, 1, 0, 64'd3, 33);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ysyx_22040632_div_unit.md
Name: ysyx_22040632_div_unit

Overview:
Iterative radix-2 integer divider for the RV64M divide/remainder group: div, divu, rem, remu, divw, divuw, remw, remuw. It is the responder side of the decoder's divide handshake. The decoder raises a request with operands and op flags. This block runs a multi-cycle restoring division and pulses out_valid with the final 64-bit result, which the decoder writes back to the GPR file in that same cycle. One operation is in flight at a time; there is no queueing.

Parameters:
XLEN, 64, datapath width; operand and result width.

Ports:
clk  input  1  clock
rrst_n  input  1  asynchronous active-low reset
in_valid  input  1  request valid; operands and flags are stable while high
in_ready  output  1  divider idle and able to accept a request
dividend  input  XLEN  rs1 value
divisor  input  XLEN  rs2 value
div_word  input  1  1 = W-form (32-bit) operation
div_signed  input  1  1 = signed (div/rem/divw/remw)
div_rem  input  1  1 = return remainder, 0 = return quotient
flush  input  1  synchronous abort of the current operation
busy  output  1  operation in progress (state != IDLE)
out_valid  output  1  single-cycle pulse; result is valid
result  output  XLEN  quotient or remainder

Behaviour:
- Clock and reset: clock clk; reset rrst_n is asynchronous and active-low.
- Reset values: state=IDLE, in_ready=1, busy=0, out_valid=0, result=0. All internal registers are cleared. Reset mid-operation discards the operation with no out_valid.
- States: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - A request is accepted on the clk edge where in_valid=1 and in_ready=1.
  - At accept, the block latches the flags, the operand magnitudes, and the sign bits.
- Operand preparation at accept:
  - W-form: use bits [31:0]. Sign-extend if div_signed, else zero-extend. N=32.
  - 64-bit form: N=64.
  - Signed operations store |dividend| and |divisor| plus the sign of each operand.
- Special cases resolve at accept and go straight to DONE (out_valid one cycle after accept):
  - Divisor == 0 (low 32 bits for W-form): quotient = all ones; remainder = original dividend.
  - Signed overflow (dividend = most negative value of width N, divisor = -1): quotient = dividend; remainder = 0.
- Normal path: IDLE -> CALC with counter = N-1.
- CALC, one quotient bit per cycle, MSB first:
  - rem' = {rem, next dividend bit}.
  - If rem' >= divisor: subtract and set quotient bit = 1; else quotient bit = 0.
  - After the cycle with counter == 0, go to DONE.
  - The CALC phase lasts exactly N cycles.
- DONE:
  - out_valid=1 for exactly one cycle, then return to IDLE.
  - in_ready=0 during DONE. The next request can be accepted the cycle after DONE.
- Sign fix-up, applied in DONE:
  - Signed quotient is negated when the operand signs differ.
  - Signed remainder takes the sign of the dividend.
  - Special-case values bypass the fix-up.
- Result width:
  - W-form: the 32-bit result is sign-extended from bit 31 into [63:32]. This applies to divuw/remuw too.
  - 64-bit form: the full value is returned.
  - result holds its last value outside DONE; it is updated only on entry to DONE.
- Latency from the accept edge to the out_valid cycle: N+1 cycles (33 for W-form, 65 for 64-bit); 1 cycle for special cases.
- flush:
  - When high in any state, the next state is IDLE with no out_valid.
  - In DONE, flush suppresses out_valid in that same cycle.
  - flush and in_valid together in IDLE: flush wins and the request is not accepted.
- in_valid while busy is ignored. The decoder holds the request until in_ready.

Test Plan:
1. divw 100 / 7: accept, then 32 CALC cycles -> out_valid exactly 33 cycles after accept, result=0x000000000000000E; remw on the same operands -> 0x0000000000000002.
2. remw -7 % 2 (dividend 0xFFFFFFF9) -> result=0xFFFFFFFFFFFFFFFF; div (64-bit) -100 / 7 -> 0xFFFFFFFFFFFFFFF2, latency 65.
3. divuw 0x12345678 / 0 -> out_valid 1 cycle after accept, result=0xFFFFFFFFFFFFFFFF; remuw 0x12345678 % 0 -> 0x0000000012345678.
4. divw 0x80000000 / 0xFFFFFFFF -> result=0xFFFFFFFF80000000, 1-cycle latency; remw on the same operands -> 0.
5. divuw 0xFFFFFFFF / 1 -> result=0xFFFFFFFFFFFFFFFF (sign-extended); remuw 0xFFFFFFFF % 16 -> 0x000000000000000F.
6. Abort and recovery:
   - Assert flush 10 cycles into CALC -> no out_valid, in_ready=1 next cycle.
   - Deassert rrst_n mid-CALC -> out_valid=0 and result=0 immediately; a new divw 9 / 3 after release -> 3.
